filter_ctrl: RTL and testbench

Sequencing controller for the boxcar averaging filter. It owns the filter's `filt_sel` and `sclr` inputs and accepts window-change requests through a valid/ready handshake. On each change it flushes the delay line, then waits out the pipeline fill before flagging the filter output valid. It sits between the front-panel/control register logic and the filter instance in the audio sample path.

---
 rtl/filter_ctrl.sv | 137 +++++++++++++
 tb/tb_filter_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/filter_ctrl.sv
// Sequencing controller for the boxcar averaging filter: flush on window change, then wait out the fill.
// Optional FILTER_CTRL_RESTART_EN: requests and soft_clr are also accepted in FLUSH/FILL and restart the flush.
//
// state    | meaning
// ST_RUN   | filter settled, requests accepted, q_valid high
// ST_FLUSH | sclr held high for FLUSH_CYCLES cycles
// ST_FILL  | delay line refilling for W + FILL_MARGIN cycles
module filter_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned FILL_MARGIN  = 2,
  parameter logic [2:0]  RESET_SEL    = 3'b000
) (
  input  logic       clk,
  input  logic       aclr,
  input  logic       req_valid,
  input  logic [2:0] req_sel,
  output logic       req_ready,
  input  logic       soft_clr,
  output logic [2:0] filt_sel,
  output logic       sclr,
  output logic       q_valid,
  output logic       busy
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_FILL  = 2'd2;

  localparam logic [5:0] FLUSH_LAST = 6'(FLUSH_CYCLES - 1);
  localparam logic [5:0] MARGIN     = 6'(FILL_MARGIN);

`ifdef FILTER_CTRL_RESTART_EN
  localparam logic RESTART_EN = 1'b1;
`else
  localparam logic RESTART_EN = 1'b0;
`endif

  logic [1:0] state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [2:0] filt_sel_q, filt_sel_d;
  logic       sclr_q, sclr_d;
  logic       q_valid_q, q_valid_d;
  logic       req_ready_q, req_ready_d;
  logic       busy_q, busy_d;

  logic [2:0] win_k;
  logic [5:0] win_len;
  logic [5:0] fill_last;
  logic       accept;

  // Window exponent saturates at 4, so selects 4..7 all mean a 16-tap window.
  always_comb begin
    win_k     = filt_sel_q[2] ? 3'd4 : filt_sel_q;
    win_len   = 6'd1 << win_k;
    fill_last = win_len + MARGIN - 6'd1;
  end

  assign accept = req_valid & req_ready_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    filt_sel_d = filt_sel_q;

    case (state_q)
      ST_RUN: begin
        // A simultaneous accept absorbs soft_clr: one flush, with the requested select.
        if ((accept && (req_sel != filt_sel_q)) || soft_clr) begin
          if (accept) filt_sel_d = req_sel;
          state_d = ST_FLUSH;
          cnt_d   = 6'd0;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          state_d = ST_FILL;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      ST_FILL: begin
        if (cnt_q == fill_last) begin
          state_d = ST_RUN;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: begin
        state_d = ST_FLUSH;
        cnt_d   = 6'd0;
      end
    endcase

    if (RESTART_EN && (state_q != ST_RUN) && (accept || soft_clr)) begin
      if (accept) filt_sel_d = req_sel;
      state_d = ST_FLUSH;
      cnt_d   = 6'd0;
    end
  end

  // Outputs are registered copies decoded from the next state.
  always_comb begin
    sclr_d      = (state_d == ST_FLUSH);
    q_valid_d   = (state_d == ST_RUN);
    busy_d      = (state_d != ST_RUN);
    req_ready_d = RESTART_EN | (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q     <= ST_FLUSH;
      cnt_q       <= 6'd0;
      filt_sel_q  <= RESET_SEL;
      sclr_q      <= 1'b1;
      q_valid_q   <= 1'b0;
      req_ready_q <= RESTART_EN;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      filt_sel_q  <= filt_sel_d;
      sclr_q      <= sclr_d;
      q_valid_q   <= q_valid_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign filt_sel  = filt_sel_q;
  assign sclr      = sclr_q;
  assign q_valid   = q_valid_q;
  assign req_ready = req_ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_filter_ctrl.sv
// Bench for filter_ctrl: directed sequence plus random traffic against a remaining-busy-cycles model.
module tb_filter_ctrl;
  localparam int FC = 2;
  localparam int FM = 2;
`ifdef FILTER_CTRL_RESTART_EN
  localparam bit RST_EN = 1'b1;
`else
  localparam bit RST_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       aclr;
  logic       req_valid;
  logic [2:0] req_sel;
  logic       req_ready;
  logic       soft_clr;
  logic [2:0] filt_sel;
  logic       sclr;
  logic       q_valid;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int m_rem;
  logic [2:0] m_sel;
  int n;

  filter_ctrl dut (
    .clk(clk), .aclr(aclr), .req_valid(req_valid), .req_sel(req_sel),
    .req_ready(req_ready), .soft_clr(soft_clr), .filt_sel(filt_sel),
    .sclr(sclr), .q_valid(q_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int fill_len(input logic [2:0] s);
    int k;
    k = (s > 3'd4) ? 4 : int'(s);
    return (1 << k) + FM;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: m_rem = busy cycles still to run including the current one; sclr while more than F remain.
  task automatic model_reset();
    m_sel = 3'b000;
    m_rem = FC + fill_len(3'b000);
  endtask

  task automatic model_edge();
    if (aclr) begin
      model_reset();
    end else if (m_rem == 0) begin
      if ((req_valid && req_sel != m_sel) || soft_clr) begin
        if (req_valid) m_sel = req_sel;
        m_rem = FC + fill_len(m_sel);
      end
    end else if (RST_EN && (req_valid || soft_clr)) begin
      if (req_valid) m_sel = req_sel;
      m_rem = FC + fill_len(m_sel);
    end else begin
      m_rem--;
    end
  endtask

  task automatic check_outputs();
    chk("sclr", sclr, m_rem > fill_len(m_sel));
    chk("busy", busy, m_rem != 0);
    chk("q_valid", q_valid, m_rem == 0);
    chk("req_ready", req_ready, RST_EN || (m_rem == 0));
    chk("filt_sel", filt_sel, m_sel);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_run(output int cnt);
    cnt = 0;
    do begin
      cyc();
      cnt++;
    end while (!q_valid && cnt < 64);
  endtask

  task automatic request(input logic [2:0] s);
    req_valid = 1'b1;
    req_sel   = s;
    cyc();
    req_valid = 1'b0;
  endtask

  initial begin
    aclr = 1'b0; req_valid = 1'b0; soft_clr = 1'b0; req_sel = 3'b000;
    model_reset();
    #3 aclr = 1'b1;
    #1;
    chk("rst_sclr_async", sclr, 1'b1);
    chk("rst_sel_async", filt_sel, 3'b000);
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    aclr = 1'b0;
    wait_run(n);
    chk("rst_to_run_edges", n, 5);

    request(3'b010);
    chk("sel2_filt_sel", filt_sel, 3'b010);
    chk("sel2_sclr", sclr, 1'b1);
    wait_run(n);
    chk("sel2_busy_len", n, 8);

    request(3'b110);
    wait_run(n);
    chk("sel6_busy_len", n, 20);

    request(3'b110);
    chk("same_sel_sclr", sclr, 1'b0);
    chk("same_sel_qvalid", q_valid, 1'b1);
    chk("same_sel_busy", busy, 1'b0);

    soft_clr = 1'b1;
    request(3'b001);
    soft_clr = 1'b0;
    chk("simul_sel", filt_sel, 3'b001);
    wait_run(n);
    chk("simul_busy_len", n, 6);

    soft_clr = 1'b1;
    cyc();
    soft_clr = 1'b0;
    chk("soft_clr_sel", filt_sel, 3'b001);
    wait_run(n);
    chk("soft_clr_busy_len", n, 6);

    request(3'b011);
    cyc();
    cyc();
    chk("in_fill_sclr", sclr, 1'b0);
    req_valid = 1'b1;
    req_sel   = 3'b101;
    cyc();
`ifdef FILTER_CTRL_RESTART_EN
    req_valid = 1'b0;
    chk("restart_sclr", sclr, 1'b1);
    chk("restart_sel", filt_sel, 3'b101);
`else
    chk("fill_ready_low", req_ready, 1'b0);
    n = 0;
    while (!q_valid && n < 64) begin
      cyc();
      n++;
    end
    chk("held_req_wait", n, 9);
    cyc();
    req_valid = 1'b0;
    chk("held_req_sclr", sclr, 1'b1);
    chk("held_req_sel", filt_sel, 3'b101);
`endif
    wait_run(n);
    chk("held_req_busy_len", n, FC + 18);

    for (int i = 0; i < 600; i++) begin
      req_valid = ($urandom_range(0, 3) == 0);
      req_sel   = 3'($urandom);
      soft_clr  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) == 0) begin
        #2 aclr = 1'b1;
        #1 model_reset();
        check_outputs();
      end
      cyc();
      aclr = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
